// File: rtl/tank_pkg.sv
// Shared definitions for the tank move scheduler: map geometry, tile codes
// and scheduler FSM states.
package tank_pkg;

    localparam int MAP_W = 20;
    localparam int MAP_H = 15;

    typedef logic [3:0] tile_t;

    localparam tile_t FREE_TILE = '0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        CHECK0,
        ISSUE1,
        CHECK1,
        DONE
    } state_t;

endpackage

// File: rtl/tile_addr.sv
// Combinational tile address generator: linear map address row*MAP_W+col
// plus an in-range flag for the given coordinates.
module tile_addr #(
    parameter int MAP_W = tank_pkg::MAP_W,
    parameter int MAP_H = tank_pkg::MAP_H
) (
    input  logic [4:0] col,
    input  logic [3:0] row,
    output logic [8:0] addr,
    output logic       in_range
);

    always_comb begin
        in_range = (int'(col) < MAP_W) && (int'(row) < MAP_H);
        addr     = 9'(int'(row) * MAP_W + int'(col));
    end

endmodule

// File: rtl/move_scheduler.sv
// Two-tank move arbiter: checks each requested target tile against the map and
// the other tank, then pulses grant/deny. Define SCHED_FAIR_EN to rotate priority.
module move_scheduler #(
    parameter int MAP_W = tank_pkg::MAP_W,
    parameter int MAP_H = tank_pkg::MAP_H
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [1:0] req,
    input  logic [4:0] tgt_col0,
    input  logic [4:0] tgt_col1,
    input  logic [3:0] tgt_row0,
    input  logic [3:0] tgt_row1,
    input  logic [4:0] cur_col0,
    input  logic [4:0] cur_col1,
    input  logic [3:0] cur_row0,
    input  logic [3:0] cur_row1,
    output logic [8:0] map_addr,
    output logic       map_rd,
    input  logic [3:0] map_data,
    output logic [1:0] grant,
    output logic [1:0] deny,
    output logic       busy,
    output logic       prio
);

    import tank_pkg::*;

    state_t     state;
    logic [1:0] req_l;
    logic [4:0] tcol [2];
    logic [3:0] trow [2];
    logic [4:0] ccol [2];
    logic [3:0] crow [2];
    logic       first_pass;
    logic [4:0] fin_col;
    logic [3:0] fin_row;

    // In IDLE the address units look at the live targets so the ISSUE0 read
    // can be registered on the same edge that latches them.
    logic [4:0] scol [2];
    logic [3:0] srow [2];
    logic [8:0] addr [2];
    logic [1:0] in_rng;

    always_comb begin
        scol[0] = (state == IDLE) ? tgt_col0 : tcol[0];
        srow[0] = (state == IDLE) ? tgt_row0 : trow[0];
        scol[1] = (state == IDLE) ? tgt_col1 : tcol[1];
        srow[1] = (state == IDLE) ? tgt_row1 : trow[1];
    end

    tile_addr #(.MAP_W(MAP_W), .MAP_H(MAP_H)) u_addr0 (
        .col(scol[0]), .row(srow[0]), .addr(addr[0]), .in_range(in_rng[0])
    );

    tile_addr #(.MAP_W(MAP_W), .MAP_H(MAP_H)) u_addr1 (
        .col(scol[1]), .row(srow[1]), .addr(addr[1]), .in_range(in_rng[1])
    );

    logic f, s;
    logic tile_free, first_ok, second_ok;

    always_comb begin
        f         = prio;
        s         = ~prio;
        tile_free = (tile_t'(map_data) == FREE_TILE);
        first_ok  = req_l[f] && in_rng[f] && tile_free &&
                    !((tcol[f] == ccol[s]) && (trow[f] == crow[s]));
        second_ok = req_l[s] && in_rng[s] && tile_free &&
                    !((tcol[s] == fin_col) && (trow[s] == fin_row));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            req_l      <= '0;
            first_pass <= 1'b0;
            fin_col    <= '0;
            fin_row    <= '0;
            map_rd     <= 1'b0;
            map_addr   <= '0;
            grant      <= '0;
            deny       <= '0;
            busy       <= 1'b0;
            prio       <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                tcol[i] <= '0;
                trow[i] <= '0;
                ccol[i] <= '0;
                crow[i] <= '0;
            end
        end else begin
            map_rd   <= 1'b0;
            map_addr <= '0;
            grant    <= '0;
            deny     <= '0;
            case (state)
                IDLE: if (frame_tick) begin
                    state   <= ISSUE0;
                    busy    <= 1'b1;
                    req_l   <= req;
                    tcol[0] <= tgt_col0;
                    trow[0] <= tgt_row0;
                    tcol[1] <= tgt_col1;
                    trow[1] <= tgt_row1;
                    ccol[0] <= cur_col0;
                    crow[0] <= cur_row0;
                    ccol[1] <= cur_col1;
                    crow[1] <= cur_row1;
                    if (req[f] && in_rng[f]) begin
                        map_rd   <= 1'b1;
                        map_addr <= addr[f];
                    end
                end
                ISSUE0: state <= CHECK0;
                CHECK0: begin
                    state      <= ISSUE1;
                    first_pass <= first_ok;
                    fin_col    <= first_ok ? tcol[f] : ccol[f];
                    fin_row    <= first_ok ? trow[f] : crow[f];
                    if (req_l[s] && in_rng[s]) begin
                        map_rd   <= 1'b1;
                        map_addr <= addr[s];
                    end
                end
                ISSUE1: state <= CHECK1;
                CHECK1: begin
                    state    <= DONE;
                    grant[f] <= first_pass;
                    deny[f]  <= req_l[f] && !first_pass;
                    grant[s] <= second_ok;
                    deny[s]  <= req_l[s] && !second_ok;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
`ifdef SCHED_FAIR_EN
                    if (|req_l)
                        prio <= ~prio;
`else
                    prio <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed corner cases plus random
// rounds against a tile-level reference model.
module tb_move_scheduler;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_tick;
    logic [1:0] req;
    logic [4:0] tgt_col0, tgt_col1, cur_col0, cur_col1;
    logic [3:0] tgt_row0, tgt_row1, cur_row0, cur_row1;
    logic [8:0] map_addr;
    logic       map_rd;
    logic [3:0] map_data;
    logic [1:0] grant, deny;
    logic       busy, prio;

    logic [3:0] mem [512];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       model_prio = 1'b0;

    always #5 Clk = ~Clk;

    // Map RAM model: data one cycle after the read strobe, junk otherwise.
    always @(posedge Clk)
        map_data <= map_rd ? mem[map_addr] : 4'($urandom_range(1, 15));

    move_scheduler #(.MAP_W(20), .MAP_H(15)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .req(req),
        .tgt_col0(tgt_col0), .tgt_col1(tgt_col1), .tgt_row0(tgt_row0), .tgt_row1(tgt_row1),
        .cur_col0(cur_col0), .cur_col1(cur_col1), .cur_row0(cur_row0), .cur_row1(cur_row1),
        .map_addr(map_addr), .map_rd(map_rd), .map_data(map_data),
        .grant(grant), .deny(deny), .busy(busy), .prio(prio)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic bit on_map(input logic [4:0] c, input logic [3:0] r);
        return (int'(c) < 20) && (int'(r) < 15);
    endfunction

    task automatic scramble_inputs();
        req      = 2'($urandom);
        tgt_col0 = 5'($urandom); tgt_row0 = 4'($urandom);
        tgt_col1 = 5'($urandom); tgt_row1 = 4'($urandom);
        cur_col0 = 5'($urandom); cur_row0 = 4'($urandom);
        cur_col1 = 5'($urandom); cur_row1 = 4'($urandom);
    endtask

    // One full round from tick (cycle t) to t+6, checking every cycle's outputs.
    task automatic run_round(input logic [1:0] r,
                             input logic [4:0] tc0, input logic [3:0] tr0,
                             input logic [4:0] tc1, input logic [3:0] tr1,
                             input logic [4:0] cc0, input logic [3:0] cr0,
                             input logic [4:0] cc1, input logic [3:0] cr1,
                             input bit scramble, input bit extra_tick, input string name);
        logic [4:0] tc [2];
        logic [4:0] cc [2];
        logic [3:0] tr [2];
        logic [3:0] cr [2];
        int         fi, si;
        bit         rd_f, rd_s, pass_f, pass_s;
        logic [8:0] ad_f, ad_s;
        logic [4:0] fin_c;
        logic [3:0] fin_r;
        logic [1:0] eg, ed;
        tc[0] = tc0; tr[0] = tr0; tc[1] = tc1; tr[1] = tr1;
        cc[0] = cc0; cr[0] = cr0; cc[1] = cc1; cr[1] = cr1;
        fi = int'(model_prio);
        si = 1 - fi;
        rd_f = r[fi] && on_map(tc[fi], tr[fi]);
        ad_f = rd_f ? 9'(int'(tr[fi]) * 20 + int'(tc[fi])) : 9'd0;
        pass_f = rd_f && (mem[ad_f] == 4'd0) && !((tc[fi] == cc[si]) && (tr[fi] == cr[si]));
        fin_c = pass_f ? tc[fi] : cc[fi];
        fin_r = pass_f ? tr[fi] : cr[fi];
        rd_s = r[si] && on_map(tc[si], tr[si]);
        ad_s = rd_s ? 9'(int'(tr[si]) * 20 + int'(tc[si])) : 9'd0;
        pass_s = rd_s && (mem[ad_s] == 4'd0) && !((tc[si] == fin_c) && (tr[si] == fin_r));
        eg = '0; ed = '0;
        eg[fi] = pass_f; ed[fi] = r[fi] && !pass_f;
        eg[si] = pass_s; ed[si] = r[si] && !pass_s;

        req = r;
        tgt_col0 = tc0; tgt_row0 = tr0; tgt_col1 = tc1; tgt_row1 = tr1;
        cur_col0 = cc0; cur_row0 = cr0; cur_col1 = cc1; cur_row1 = cr1;
        frame_tick = 1'b1;
        step();                                   // t+1 ISSUE0
        frame_tick = 1'b0;
        if (scramble) scramble_inputs();
        n_tests++; if (map_rd !== rd_f) begin n_fail++; $display("FAIL %s rd0: got %b want %b", name, map_rd, rd_f); end
        n_tests++; if (map_addr !== ad_f) begin n_fail++; $display("FAIL %s addr0: got %0d want %0d", name, map_addr, ad_f); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy1: got %b want 1", name, busy); end
        step();                                   // t+2 CHECK0
        if (extra_tick) frame_tick = 1'b1;
        n_tests++; if ({map_rd, map_addr} !== 10'd0) begin n_fail++; $display("FAIL %s rd_check0: got %b/%0d want 0/0", name, map_rd, map_addr); end
        step();                                   // t+3 ISSUE1
        frame_tick = 1'b0;
        n_tests++; if (map_rd !== rd_s) begin n_fail++; $display("FAIL %s rd1: got %b want %b", name, map_rd, rd_s); end
        n_tests++; if (map_addr !== ad_s) begin n_fail++; $display("FAIL %s addr1: got %0d want %0d", name, map_addr, ad_s); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy3: got %b want 1", name, busy); end
        step();                                   // t+4 CHECK1
        n_tests++; if ({grant, deny} !== 4'd0) begin n_fail++; $display("FAIL %s early_pulse: got g=%b d=%b want 00/00", name, grant, deny); end
        step();                                   // t+5 DONE
        n_tests++; if (grant !== eg) begin n_fail++; $display("FAIL %s grant: got %b want %b", name, grant, eg); end
        n_tests++; if (deny !== ed) begin n_fail++; $display("FAIL %s deny: got %b want %b", name, deny, ed); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy5: got %b want 1", name, busy); end
`ifdef SCHED_FAIR_EN
        if (|r) model_prio = ~model_prio;
`endif
        step();                                   // t+6 IDLE
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy6: got %b want 0", name, busy); end
        n_tests++; if ({grant, deny} !== 4'd0) begin n_fail++; $display("FAIL %s late_pulse: got g=%b d=%b want 00/00", name, grant, deny); end
        n_tests++; if (prio !== model_prio) begin n_fail++; $display("FAIL %s prio: got %b want %b", name, prio, model_prio); end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        frame_tick = 1'b1;
        scramble_inputs();
        req = 2'b11;
        repeat (3) step();
        n_tests++; if ({busy, map_rd, map_addr} !== 11'd0) begin n_fail++; $display("FAIL reset_bus: got busy=%b rd=%b addr=%0d want 0", busy, map_rd, map_addr); end
        n_tests++; if ({grant, deny, prio} !== 5'd0) begin n_fail++; $display("FAIL reset_out: got g=%b d=%b p=%b want 0", grant, deny, prio); end
        frame_tick = 1'b0;
        Reset_n = 1'b1;
        model_prio = 1'b0;
        step();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_basic_grant();
        mem[65] = 4'd0;
        run_round(2'b01, 5'd5, 4'd3, 5'd0, 4'd0, 5'd1, 4'd1, 5'd9, 4'd9, 1'b1, 1'b0, "basic_grant");
    endtask

    task automatic test_mid_reset();
        mem[42] = 4'd0;
        req = 2'b11; tgt_col0 = 5'd2; tgt_row0 = 4'd2; tgt_col1 = 5'd3; tgt_row1 = 4'd3;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();                                   // t+3
        Reset_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        n_tests++; if ({map_rd, map_addr, prio} !== 11'd0) begin n_fail++; $display("FAIL mid_reset_rd: got rd=%b addr=%0d p=%b want 0", map_rd, map_addr, prio); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++; if ({grant, deny} !== 4'd0) begin n_fail++; $display("FAIL mid_reset_pulse: got g=%b d=%b want 00/00", grant, deny); end
        end
        Reset_n = 1'b1;
        model_prio = 1'b0;
        step();
        n_tests++; if ({busy, grant, deny} !== 5'd0) begin n_fail++; $display("FAIL mid_reset_after: got busy=%b g=%b d=%b want 0", busy, grant, deny); end
    endtask

    task automatic test_same_tile();
        mem[84] = 4'd0;
        run_round(2'b11, 5'd4, 4'd4, 5'd4, 4'd4, 5'd0, 4'd0, 5'd1, 4'd0, 1'b1, 1'b0, "same_tile");
    endtask

    task automatic test_out_of_range();
        run_round(2'b10, 5'd0, 4'd0, 5'd21, 4'd2, 5'd3, 4'd3, 5'd6, 4'd6, 1'b1, 1'b0, "out_of_range");
        run_round(2'b11, 5'd19, 4'd15, 5'd19, 4'd14, 5'd3, 4'd3, 5'd6, 4'd6, 1'b0, 1'b0, "edge_range");
    endtask

    task automatic test_busy_ignore();
        mem[10 * 20 + 8] = 4'd3;
        run_round(2'b01, 5'd8, 4'd10, 5'd0, 4'd0, 5'd8, 4'd9, 5'd2, 4'd2, 1'b0, 1'b1, "busy_ignore");
        step();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_restart: busy got %b want 0", busy); end
    endtask

    task automatic test_tank_blocks();
        mem[7 * 20 + 7] = 4'd0;
        run_round(2'b10, 5'd0, 4'd0, 5'd7, 4'd7, 5'd7, 4'd7, 5'd7, 4'd8, 1'b1, 1'b0, "tank_blocks");
    endtask

    task automatic test_random();
        logic [4:0] c [4];
        logic [3:0] r [4];
        int         mode;
        for (int i = 0; i < 512; i++)
            mem[i] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 4; k++) begin
                c[k] = 5'($urandom_range(0, 22));
                r[k] = 4'($urandom_range(0, 15));
            end
            mode = $urandom_range(0, 3);
            if (mode == 1) begin c[1] = c[0]; r[1] = r[0]; end  // same target
            if (mode == 2) begin c[1] = c[2]; r[1] = r[2]; end  // tank1 onto tank0
            if (mode == 3) begin c[0] = c[3]; r[0] = r[3]; end  // tank0 onto tank1
            run_round(2'($urandom), c[0], r[0], c[1], r[1], c[2], r[2], c[3], r[3],
                      1'b1, 1'($urandom_range(0, 1)), "random");
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 4'($urandom_range(1, 15));
        frame_tick = 1'b0;
        test_reset();
        test_basic_grant();
        test_mid_reset();
        test_same_tile();
        test_out_of_range();
        test_busy_ignore();
        test_tank_blocks();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
